// File: rtl/cic2_decim_fir128.sv
// Decimation filter for a delta-sigma ADC back end: a second-order CIC
// decimator (2 integrators, downsample by DECIM, 2 combs) followed by a
// 128-tap serial-MAC FIR. Every intermediate stage is exported for debug.
//
// Ports:
//   clk          clock, all logic on posedge
//   reset        synchronous, active-low
//   xin          signed input sample, one per clock
//   y1_out       integrator 1 state
//   y2_out       integrator 2 state
//   ds_out       downsampled y2, ds_valid strobes on update
//   comb1_out    comb 1 output, comb1_valid strobes on update
//   comb2_out    comb 2 output (CIC result), comb2_valid strobes on update
//   fir_out      FIR output, fir_valid strobes on update
//
// DECIM must be >= 131 so the serial FIR finishes between CIC outputs.
module cic2_decim_fir128 #(
  parameter int unsigned DECIM     = 256,
  parameter int unsigned FIR_SHIFT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] xin,
  output logic [31:0] y1_out,
  output logic [31:0] y2_out,
  output logic [31:0] ds_out,
  output logic        ds_valid,
  output logic [31:0] comb1_out,
  output logic        comb1_valid,
  output logic [31:0] comb2_out,
  output logic        comb2_valid,
  output logic [31:0] fir_out,
  output logic        fir_valid
);

  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned NTAPS = 128;
  localparam int unsigned K_W   = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } fir_state_t;

  // Coefficient ROM: all taps are 1 by default
  function automatic logic signed [15:0] coef(input logic [K_W-1:0] idx);
    case (idx)
      default: coef = 16'sd1;
    endcase
  endfunction

  logic [CNT_W-1:0]   cnt;
  logic [31:0]        d1;
  logic [31:0]        d2;
  logic signed [31:0] taps [NTAPS];
  logic signed [63:0] acc;
  logic [K_W-1:0]     k;
  fir_state_t         state;
  logic signed [47:0] prod_c;

  assign prod_c = taps[k] * coef(k);

  // Integrators and downsampler; ds_out captures y2 before this edge's update
  always_ff @(posedge clk) begin
    if (!reset) begin
      y1_out   <= 32'd0;
      y2_out   <= 32'd0;
      ds_out   <= 32'd0;
      ds_valid <= 1'b0;
      cnt      <= '0;
    end else begin
      y1_out   <= y1_out + xin;
      y2_out   <= y2_out + y1_out;
      ds_valid <= 1'b0;
      if (cnt == CNT_W'(DECIM - 1)) begin
        cnt      <= '0;
        ds_out   <= y2_out;
        ds_valid <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Two comb stages at the decimated rate
  always_ff @(posedge clk) begin
    if (!reset) begin
      comb1_out   <= 32'd0;
      comb1_valid <= 1'b0;
      comb2_out   <= 32'd0;
      comb2_valid <= 1'b0;
      d1          <= 32'd0;
      d2          <= 32'd0;
    end else begin
      comb1_valid <= 1'b0;
      comb2_valid <= 1'b0;
      if (ds_valid) begin
        comb1_out   <= ds_out - d1;
        d1          <= ds_out;
        comb1_valid <= 1'b1;
      end
      if (comb1_valid) begin
        comb2_out   <= comb1_out - d2;
        d2          <= comb1_out;
        comb2_valid <= 1'b1;
      end
    end
  end

  // Serial-MAC FIR; a new CIC sample always restarts the MAC
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      acc       <= 64'sd0;
      k         <= '0;
      fir_out   <= 32'd0;
      fir_valid <= 1'b0;
      for (int i = 0; i < int'(NTAPS); i++) taps[i] <= 32'sd0;
    end else begin
      fir_valid <= 1'b0;
      if (state == S_DONE) begin
        fir_out   <= 32'(acc >>> FIR_SHIFT);
        fir_valid <= 1'b1;
      end
      if (comb2_valid) begin
        for (int i = int'(NTAPS) - 1; i > 0; i--) taps[i] <= taps[i-1];
        taps[0] <= comb2_out;
        acc     <= 64'sd0;
        k       <= '0;
        state   <= S_MAC;
      end else begin
        case (state)
          S_MAC: begin
            acc <= acc + {{16{prod_c[47]}}, prod_c};
            k   <= k + K_W'(1);
            if (k == K_W'(NTAPS - 1)) state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cic2_decim_fir128.sv
// Self-checking bench for cic2_decim_fir128: randomized and directed input
// phases compared every cycle against an event-scheduled reference model.
module tb_cic2_decim_fir128;

  localparam int unsigned DECIM     = 256;
  localparam int unsigned FIR_SHIFT = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] xin;
  logic [31:0] y1_out, y2_out, ds_out, comb1_out, comb2_out, fir_out;
  logic        ds_valid, comb1_valid, comb2_valid, fir_valid;

  int n_checks = 0;
  int n_errors = 0;

  cic2_decim_fir128 #(.DECIM(DECIM), .FIR_SHIFT(FIR_SHIFT)) dut (
    .clk(clk), .reset(reset), .xin(xin),
    .y1_out(y1_out), .y2_out(y2_out),
    .ds_out(ds_out), .ds_valid(ds_valid),
    .comb1_out(comb1_out), .comb1_valid(comb1_valid),
    .comb2_out(comb2_out), .comb2_valid(comb2_valid),
    .fir_out(fir_out), .fir_valid(fir_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge count since release, running sums, and a schedule
  // of decimated events (comb1 +1, comb2 +2, FIR +130 after comb2).
  int          n;
  int          c1_due, c2_due, fir_due;
  logic [31:0] m_y1, m_y2, m_ds, m_c1, m_c2, m_fir, m_d1, m_d2;
  logic        m_dsv, m_c1v, m_c2v, m_firv;
  logic signed [31:0] hist [128];

  function automatic longint h(input int idx);
    h = (idx >= 0) ? 64'sd1 : 64'sd0;
  endfunction

  task automatic model_edge(input logic r, input logic [31:0] x);
    logic [31:0] pre_y2;
    longint s;
    if (!r) begin
      n = 0; c1_due = -1; c2_due = -1; fir_due = -1;
      m_y1 = 0; m_y2 = 0; m_ds = 0; m_c1 = 0; m_c2 = 0; m_fir = 0;
      m_d1 = 0; m_d2 = 0;
      m_dsv = 0; m_c1v = 0; m_c2v = 0; m_firv = 0;
      for (int i = 0; i < 128; i++) hist[i] = 0;
    end else begin
      n++;
      pre_y2 = m_y2;
      m_y2 = m_y2 + m_y1;
      m_y1 = m_y1 + x;
      m_dsv = 0; m_c1v = 0; m_c2v = 0; m_firv = 0;
      if (n % int'(DECIM) == 0) begin
        m_ds = pre_y2; m_dsv = 1; c1_due = n + 1;
      end
      if (n == c1_due) begin
        m_c1 = m_ds - m_d1; m_d1 = m_ds; m_c1v = 1; c2_due = n + 1;
      end
      if (n == c2_due) begin
        m_c2 = m_c1 - m_d2; m_d2 = m_c1; m_c2v = 1;
        for (int i = 127; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = m_c2;
        fir_due = n + 130;
      end
      if (n == fir_due) begin
        s = 0;
        for (int i = 0; i < 128; i++) s += longint'(hist[i]) * h(i);
        m_fir = 32'(s >>> FIR_SHIFT);
        m_firv = 1;
      end
    end
  endtask

  // Apply inputs, clock once, update model, compare all outputs 1 ns later
  task automatic step(input logic r, input logic [31:0] x);
    reset = r;
    xin   = x;
    @(posedge clk);
    model_edge(r, x);
    #1;
    check("y1",          y1_out,             m_y1);
    check("y2",          y2_out,             m_y2);
    check("ds_out",      ds_out,             m_ds);
    check("ds_valid",    32'(ds_valid),      32'(m_dsv));
    check("comb1_out",   comb1_out,          m_c1);
    check("comb1_valid", 32'(comb1_valid),   32'(m_c1v));
    check("comb2_out",   comb2_out,          m_c2);
    check("comb2_valid", 32'(comb2_valid),   32'(m_c2v));
    check("fir_out",     fir_out,            m_fir);
    check("fir_valid",   32'(fir_valid),     32'(m_firv));
  endtask

  int ds_seen;
  int c2_cycle;
  int cyc;
  logic found;

  initial begin
    reset = 1'b0;
    xin   = 32'd5;

    // Held reset with non-zero input: everything stays 0
    for (int i = 0; i < 20; i++) step(1'b0, 32'd5);
    check("rst_fir_out", fir_out, 32'd0);

    // Constant +1: closed-form values plus full settling of the FIR line
    ds_seen  = 0;
    c2_cycle = -1;
    for (int i = 1; i <= 131 * int'(DECIM) + 200; i++) begin
      step(1'b1, 32'd1);
      if (i == 100) begin
        check("y1_closed", y1_out, 32'd100);
        check("y2_closed", y2_out, 32'd4950);
      end
      if (ds_valid) begin
        ds_seen++;
        if (ds_seen == 1) check("ds_first_edge", 32'(i), DECIM);
        if (ds_seen == 1) check("ds_first", ds_out, 32'd32385);
        if (ds_seen == 2) check("ds_second", ds_out, 32'd130305);
      end
      if (comb2_valid) c2_cycle = i;
      if (fir_valid) check("fir_latency", 32'(i - c2_cycle), 32'd130);
    end
    check("comb2_settled", comb2_out, 32'd65536);
    check("fir_settled",   fir_out,   32'd65536);

    // Constant -1
    step(1'b0, 32'd0);
    for (int i = 0; i < 6 * int'(DECIM); i++) step(1'b1, 32'hFFFF_FFFF);
    check("comb2_neg", comb2_out, 32'hFFFF_0000);

    // Full-scale positive: integrators wrap, comb result is DECIM^2*x mod 2^32
    step(1'b0, 32'd0);
    for (int i = 0; i < 5 * int'(DECIM); i++) step(1'b1, 32'h7FFF_FFFF);
    check("comb2_fullscale", comb2_out, 32'(64'(DECIM) * 64'(DECIM) * 64'h7FFF_FFFF));

    // Random input
    step(1'b0, 32'd0);
    for (int i = 0; i < 8 * int'(DECIM); i++) step(1'b1, $urandom);

    // Reset in the middle of a MAC, then the +1 sequence must repeat exactly
    step(1'b0, 32'd0);
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < 4 * int'(DECIM)) begin
      step(1'b1, 32'd1);
      cyc++;
      if (comb2_valid) found = 1'b1;
    end
    check("mac_start_seen", 32'(found), 32'd1);
    for (int i = 0; i < 50; i++) step(1'b1, 32'd1);
    step(1'b0, 32'd1);
    check("midmac_fir_valid", 32'(fir_valid), 32'd0);
    check("midmac_fir_out",   fir_out,        32'd0);
    ds_seen = 0;
    for (int i = 1; i <= 3 * int'(DECIM) + 140; i++) begin
      step(1'b1, 32'd1);
      if (ds_valid) begin
        ds_seen++;
        if (ds_seen == 1) check("rerun_ds_first", ds_out, 32'd32385);
        if (ds_seen == 2) check("rerun_ds_second", ds_out, 32'd130305);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
